// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and widths for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int LAT_CNT_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_perf.sv
// Saturating stall-cycle counters for the fetch and data ports.
// Only instantiated when MEM_PORT_ARBITER_PERF_EN is defined.
module mem_port_arbiter_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_mem,
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_dm_stall
);

  logic [31:0] if_cnt_q, if_cnt_d;
  logic [31:0] dm_cnt_q, dm_cnt_d;

  // Count stalled cycles, holding at all-ones instead of wrapping.
  always_comb begin
    if_cnt_d = if_cnt_q;
    dm_cnt_d = dm_cnt_q;
    if (stall_if && (if_cnt_q != '1)) if_cnt_d = if_cnt_q + 32'd1;
    if (stall_mem && (dm_cnt_q != '1)) dm_cnt_d = dm_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_cnt_q <= '0;
      dm_cnt_q <= '0;
    end else begin
      if_cnt_q <= if_cnt_d;
      dm_cnt_q <= dm_cnt_d;
    end
  end

  assign perf_if_stall = if_cnt_q;
  assign perf_dm_stall = dm_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-port memory between the fetch
// (IF) and load/store (DM) stages. Data wins ties unless data was the last
// owner, so fetch can never starve. Stall counters are built only when
// MEM_PORT_ARBITER_PERF_EN is defined; otherwise the perf ports read 0.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no access in flight; arbitrate at the next edge
//   ST_BUSY | access in flight; capture and pulse ready when cnt reaches 1
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall
);

  state_e                 state_q, state_d;
  owner_e                 owner_q, owner_d;
  owner_e                 last_q, last_d;
  logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]      dm_rdata_q, dm_rdata_d;
  logic                   if_ready_q, if_ready_d;
  logic                   dm_ready_q, dm_ready_d;
  logic                   grant_dm, grant_if;

  // Data has priority except when it also owned the previous access.
  assign grant_dm = dm_req & (~if_req | (last_q == OWN_IF));
  assign grant_if = if_req & ~grant_dm;

  // Next-state and output decode; strobes default low every cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_dm) begin
          owner_d     = OWN_DM;
          last_d      = OWN_DM;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (grant_if) begin
          owner_d    = OWN_IF;
          last_d     = OWN_IF;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
        if (grant_dm || grant_if) begin
          mem_en_d = 1'b1;
          cnt_d    = LAT_CNT_W'(MEM_LAT);
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - LAT_CNT_W'(1);
        if (cnt_q <= LAT_CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = dm_req & ~dm_ready_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
  mem_port_arbiter_perf u_perf (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .stall_mem     (stall_mem),
    .perf_if_stall (perf_if_stall),
    .perf_dm_stall (perf_dm_stall)
  );
`else
  assign perf_if_stall = 32'd0;
  assign perf_dm_stall = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter with a transaction-timeline reference
// model and a behavioural fixed-latency memory.
module tb_mem_port_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_if;
  logic          stall_mem;
  logic [31:0]   perf_if_stall;
  logic [31:0]   perf_dm_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem),
    .perf_if_stall(perf_if_stall), .perf_dm_stall(perf_dm_stall)
  );

  // Behavioural memory: data appears LAT edges after the strobe edge, garbage otherwise.
  logic [DW-1:0] env_mem [256];
  logic          en_s = 1'b0;
  logic          we_s = 1'b0;
  logic [AW-1:0] addr_s = '0;
  logic [DW-1:0] wd_s = '0;

  always @(negedge clk) begin
    en_s   = mem_en;
    we_s   = mem_we;
    addr_s = mem_addr;
    wd_s   = mem_wdata;
  end

  always @(posedge clk) begin
    #1;
    if (en_s) begin
      if (we_s) begin
        env_mem[addr_s] = wd_s;
        mem_rdata = $urandom;
      end else begin
        mem_rdata = env_mem[addr_s];
      end
      en_s = 1'b0;
    end else begin
      mem_rdata = $urandom;
    end
  end

  // Reference model: each grant books a slot on a timeline of edges.
  logic [DW-1:0] ref_mem [256];
  int            n_vec = 0;
  int            n_err = 0;
  int            m_edge, m_done;
  logic          m_busy, m_own, m_last, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_rd;
  logic [DW-1:0] e_if_rd, e_dm_rd;
  logic          e_if_rdy, e_dm_rdy, e_en;
  logic [31:0]   e_pif, e_pdm;
  int            ev_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_edge = 0; m_done = 0; m_own = 1'b0; m_last = 1'b0;
    m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;
    e_if_rd = '0; e_dm_rd = '0; e_if_rdy = 1'b0; e_dm_rdy = 1'b0; e_en = 1'b0;
    e_pif = '0; e_pdm = '0;
  endtask

  task automatic model_edge();
    logic take_dm;
    if (if_req && !e_if_rdy && e_pif != 32'hFFFF_FFFF) e_pif++;
    if (dm_req && !e_dm_rdy && e_pdm != 32'hFFFF_FFFF) e_pdm++;
    e_if_rdy = 1'b0;
    e_dm_rdy = 1'b0;
    e_en     = 1'b0;
    if (m_busy) begin
      if (m_edge == m_done) begin
        m_busy = 1'b0;
        if (!m_own) begin
          e_if_rdy = 1'b1;
          e_if_rd  = m_rd;
        end else begin
          e_dm_rdy = 1'b1;
          if (!m_we) e_dm_rd = m_rd;
        end
      end
    end else if (if_req || dm_req) begin
      take_dm = dm_req && (!if_req || !m_last);
      m_busy  = 1'b1;
      m_own   = take_dm;
      m_last  = take_dm;
      m_done  = m_edge + LAT;
      e_en    = 1'b1;
      if (take_dm) begin
        m_we = dm_we; m_addr = dm_addr; m_wd = dm_wdata;
        if (dm_we) ref_mem[dm_addr] = dm_wdata;
        else m_rd = ref_mem[dm_addr];
      end else begin
        m_we = 1'b0; m_addr = if_addr; m_rd = ref_mem[if_addr];
      end
    end
    m_edge++;
  endtask

  task automatic check_outputs();
    chk("mem_en", 32'(mem_en), 32'(e_en));
    if (e_en) begin
      chk("mem_we", 32'(mem_we), 32'(m_we));
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
    end
    chk("if_ready", 32'(if_ready), 32'(e_if_rdy));
    chk("dm_ready", 32'(dm_ready), 32'(e_dm_rdy));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("dm_rdata", dm_rdata, e_dm_rd);
    chk("stall_if", 32'(stall_if), 32'(if_req & ~e_if_rdy));
    chk("stall_mem", 32'(stall_mem), 32'(dm_req & ~e_dm_rdy));
`ifdef MEM_PORT_ARBITER_PERF_EN
    chk("perf_if", perf_if_stall, e_pif);
    chk("perf_dm", perf_dm_stall, e_pdm);
`else
    chk("perf_if", perf_if_stall, 32'd0);
    chk("perf_dm", perf_dm_stall, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
    if (if_ready) ev_q.push_back(0);
    if (dm_ready) ev_q.push_back(1);
  endtask

  // Requesters hold req until ready; addr/data may wander since only grant-time values count.
  task automatic drive_random();
    if (!if_req) begin
      if ($urandom_range(2) == 0) if_req = 1'b1;
    end else if (e_if_rdy) begin
      if_req = 1'($urandom_range(1));
    end
    if (!dm_req) begin
      if ($urandom_range(2) == 0) dm_req = 1'b1;
    end else if (e_dm_rdy) begin
      dm_req = 1'($urandom_range(1));
    end
    if_addr  = AW'($urandom_range(15));
    dm_addr  = AW'($urandom_range(15));
    dm_we    = 1'($urandom_range(1));
    dm_wdata = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Fetch only.
    env_mem[4] = 32'h8C22_0000;
    ref_mem[4] = 32'h8C22_0000;
    if_req = 1'b1; if_addr = 8'h04;
    for (int i = 0; i < 10 && !e_if_rdy; i++) step();
    chk("fetch_ready", 32'(if_ready), 32'd1);
    chk("fetch_rdata", if_rdata, 32'h8C22_0000);
    if_req = 1'b0;
    step();

    // Store.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 8'h10; dm_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && !e_dm_rdy; i++) step();
    chk("store_ready", 32'(dm_ready), 32'd1);
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    chk("store_mem", env_mem[16], 32'hDEAD_BEEF);

    // Contention from reset release: DM, IF, DM, IF.
    if_req = 1'b1; if_addr = 8'h20; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h30;
    do_reset();
    ev_q.delete();
    for (int i = 0; i < 12; i++) step();
    chk("cont_count", 32'(ev_q.size()), 32'd4);
    if (ev_q.size() >= 4) begin
      chk("cont_0", 32'(ev_q[0]), 32'd1);
      chk("cont_1", 32'(ev_q[1]), 32'd0);
      chk("cont_2", 32'(ev_q[2]), 32'd1);
      chk("cont_3", 32'(ev_q[3]), 32'd0);
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Abandoned fetch still completes.
    if_req = 1'b1; if_addr = 8'h05;
    for (int i = 0; i < 10 && !e_en; i++) step();
    if_req = 1'b0;
    for (int i = 0; i < 10 && !e_if_rdy; i++) step();
    chk("abandon_ready", 32'(if_ready), 32'd1);
    step();

    // Data request arriving mid-fetch waits, then is served.
    ev_q.delete();
    if_req = 1'b1; if_addr = 8'h06;
    for (int i = 0; i < 10 && !e_en; i++) step();
    step();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h10;
    for (int i = 0; i < 20 && !e_dm_rdy; i++) begin
      step();
      if (e_if_rdy) if_req = 1'b0;
    end
    chk("pend_count", 32'(ev_q.size()), 32'd2);
    if (ev_q.size() >= 2) begin
      chk("pend_0", 32'(ev_q[0]), 32'd0);
      chk("pend_1", 32'(ev_q[1]), 32'd1);
    end
    chk("pend_rdata", dm_rdata, 32'hDEAD_BEEF);
    dm_req = 1'b0;
    step();

    // Asynchronous reset one cycle after a grant.
    ev_q.delete();
    if_req = 1'b1; if_addr = 8'h04;
    for (int i = 0; i < 10 && !e_en; i++) step();
    chk("pre_rst_en", 32'(mem_en), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    for (int i = 0; i < 10 && !e_if_rdy; i++) step();
    chk("rst_fresh_rdata", if_rdata, 32'h8C22_0000);
    chk("rst_events", 32'(ev_q.size()), 32'd1);
    if_req = 1'b0;
    step();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      drive_random();
      step();
    end
    if_req = 1'b0; dm_req = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Grants one access at a time, sequences a fixed-latency memory access, returns read data to the owner and drives per-stage stall signals to the pipeline registers.
- Data requests have priority, with an alternation rule so that fetch is never starved.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  freeze PC and IF/ID.
- stall_mem  out  1  freeze pipeline up to and including EX/MEM.
- perf_if_stall  out  32  fetch stall-cycle count (optional feature).
- perf_dm_stall  out  32  data stall-cycle count (optional feature).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=IF, last_grant=IF.
  - mem_en, mem_we, if_ready and dm_ready = 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata = 0.
  - cnt=0; perf counters = 0.
- FSM states: IDLE and BUSY.
- IDLE, at a clock edge:
  - Only dm_req: grant DM.
  - Only if_req: grant IF.
  - Both: grant IF if last_grant=DM, else grant DM.
  - Neither: stay in IDLE.
- On a grant at edge E0:
  - Register owner, mem_addr and mem_wdata; mem_we=dm_we for DM, 0 for IF.
  - mem_en=1 for exactly the cycle after E0.
  - cnt=MEM_LAT; state→BUSY; last_grant=owner.
- BUSY:
  - cnt decrements each edge; mem_en=0 after the first BUSY cycle.
  - At edge E0+MEM_LAT: capture mem_rdata into the owner's rdata register (loads and fetches only; on a store, dm_rdata holds its value), pulse the owner's ready for one cycle, state→IDLE.
- Throughput and timing:
  - One access per MEM_LAT+1 cycles.
  - The next grant is at the edge after the ready pulse.
  - The ready pulse and the new IDLE arbitration do not overlap.
- Requester abandonment: a requester deasserting req while its access is in flight does not cancel it; the access completes and ready still pulses.
- Requests from the non-owner during BUSY are held pending, never dropped.
- Stall outputs (combinational): stall_if = if_req & ~if_ready; stall_mem = dm_req & ~dm_ready.
- Address and data inputs are sampled only at grant; later changes have no effect.
- MEM_LAT=1: BUSY lasts one cycle, with mem_en and capture in the same BUSY cycle.
- Reset mid-BUSY: the access is abandoned, no ready pulse is issued, and mem_en drops immediately.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined:
  - perf_if_stall increments each cycle stall_if=1.
  - perf_dm_stall increments each cycle stall_mem=1.
  - Both counters saturate at 0xFFFFFFFF and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - state encoding (ST_IDLE, ST_BUSY);
  - owner encoding (OWN_IF=0, OWN_DM=1);
  - DATA_W default of 32;
  - LAT_CNT_W=4.
- One natural sub-module, mem_port_arbiter_perf: the two saturating counters, instantiated only under the macro.

Test Plan (MEM_LAT=2):
- Fetch only: if_req=1, if_addr=0x04, mem_rdata=0x8C220000 at capture → mem_en high exactly 1 cycle after grant, if_ready pulses 3 cycles after the grant edge, if_rdata=0x8C220000, stall_if high until that pulse.
- Store: dm_req=1, dm_we=1, dm_addr=0x10, dm_wdata=0xDEADBEEF → mem_we=1, mem_addr=0x10, mem_wdata=0xDEADBEEF for one cycle, dm_ready pulses once, dm_rdata unchanged.
- Contention:
  - Stimulus: if_req and dm_req both held from reset release.
  - Required grant order: DM, IF, DM, IF.
  - Required timing: each access completes 3 cycles after its grant and grants are spaced 3 cycles apart.
- Pending non-owner: dm_req rises mid-fetch → IF completes first, DM is granted at the next edge, dm_ready follows 3 cycles later.
- Async reset mid-BUSY: rst pulsed one cycle after a grant → mem_en=0 immediately, no ready pulse, IDLE after release, a fresh request is served normally.
- PERF_EN defined: 10 cycles with stall_if=1 → perf_if_stall=10; macro undefined → reads 0.
